// File: rtl/haraka_s_pkg.sv
// Shared constants and state encoding for the Haraka-S sponge front end.
// Padding support is compiled in only when HARAKA_S_PAD_EN is defined.
package haraka_s_pkg;

    localparam int unsigned RATE_BITS  = 256;
    localparam int unsigned STATE_BITS = 512;

    localparam logic [7:0] PAD_FIRST = 8'h1F;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    // Pad-only block absorbed when the last beat carried a full 32 bytes.
    localparam logic [RATE_BITS-1:0] PAD_BLOCK = {PAD_LAST, 240'h0, PAD_FIRST};

    typedef logic [2:0] sponge_state_t;

    localparam sponge_state_t StIdle    = 3'd0;
    localparam sponge_state_t StPermAbs = 3'd1;
    localparam sponge_state_t StPad     = 3'd2;
    localparam sponge_state_t StSqueeze = 3'd3;
    localparam sponge_state_t StPermSq  = 3'd4;

    function automatic logic [7:0] out_block_count(input logic [7:0] cfg);
        return (cfg == 8'd0) ? 8'd1 : cfg;
    endfunction

endpackage

// File: rtl/haraka_s_pad.sv
// Masks and pads the final message beat; flags when a separate pad-only block is needed.
// With HARAKA_S_PAD_EN undefined the beat passes through untouched.
module haraka_s_pad
    import haraka_s_pkg::*;
(
    input  logic [RATE_BITS-1:0] in_data,
    input  logic [5:0]           in_bytes,
    output logic [RATE_BITS-1:0] padded,
    output logic                 pad_pending
);

`ifdef HARAKA_S_PAD_EN
    logic [5:0] nbytes;

    always_comb begin
        nbytes      = (in_bytes > 6'd32) ? 6'd32 : in_bytes;
        padded      = in_data;
        pad_pending = 1'b0;
        if (nbytes == 6'd32) begin
            pad_pending = 1'b1;
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (k >= int'(nbytes)) begin
                    padded[8*k +: 8] = 8'h00;
                end
            end
            // Both pad bytes land on byte 31 when in_bytes is 31, giving 0x9F.
            padded[{nbytes[4:0], 3'b000} +: 8] = padded[{nbytes[4:0], 3'b000} +: 8] ^ PAD_FIRST;
            padded[RATE_BITS-1 -: 8]           = padded[RATE_BITS-1 -: 8] ^ PAD_LAST;
        end
    end
`else
    logic unused_bytes;

    assign unused_bytes = ^in_bytes;
    assign padded       = in_data;
    assign pad_pending  = 1'b0;
`endif

endmodule

// File: rtl/haraka_s_sponge.sv
// Haraka-S sponge front end: absorbs message beats, drives the permutation handshake,
// squeezes output blocks. Padding is enabled by defining HARAKA_S_PAD_EN.
module haraka_s_sponge
    import haraka_s_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            cfg_out_blocks,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RATE_BITS-1:0]  in_data,
    input  logic                  in_last,
    input  logic [5:0]            in_bytes,
    output logic                  perm_start,
    output logic [STATE_BITS-1:0] perm_in,
    input  logic                  perm_done,
    input  logic [STATE_BITS-1:0] perm_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RATE_BITS-1:0]  out_data,
    output logic                  busy
);

    sponge_state_t         fsm_q, fsm_d;
    logic [STATE_BITS-1:0] state_q, state_d;
    logic [7:0]            cfg_q, cfg_d;
    logic [7:0]            remaining_q, remaining_d;
    logic                  in_msg_q, in_msg_d;
    logic                  last_q, last_d;
    logic                  start_q, start_d;
    logic                  init_q;

    logic [RATE_BITS-1:0]  padded;
    logic                  pad_pending;
    logic                  accept;

    haraka_s_pad u_pad (
        .in_data     (in_data),
        .in_bytes    (in_bytes),
        .padded      (padded),
        .pad_pending (pad_pending)
    );

`ifdef HARAKA_S_PAD_EN
    logic pad_pend_q, pad_pend_d;
`else
    logic unused_pad;
    assign unused_pad = pad_pending;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        cfg_d       = cfg_q;
        remaining_d = remaining_q;
        in_msg_d    = in_msg_q;
        last_d      = last_q;
        start_d     = 1'b0;
`ifdef HARAKA_S_PAD_EN
        pad_pend_d  = pad_pend_q;
`endif
        case (fsm_q)
            StIdle: begin
                if (accept) begin
                    state_d[RATE_BITS-1:0] = state_q[RATE_BITS-1:0] ^ (in_last ? padded : in_data);
                    // Output count is latched once per message, on its first beat.
                    if (!in_msg_q) begin
                        cfg_d = out_block_count(cfg_out_blocks);
                    end
                    in_msg_d = 1'b1;
                    last_d   = in_last;
`ifdef HARAKA_S_PAD_EN
                    pad_pend_d = in_last && pad_pending;
`endif
                    start_d  = 1'b1;
                    fsm_d    = StPermAbs;
                end
            end
            StPermAbs: begin
                if (perm_done) begin
                    state_d = perm_out;
                    if (last_q) begin
                        fsm_d       = StSqueeze;
                        remaining_d = cfg_q;
                    end else begin
                        fsm_d = StIdle;
                    end
`ifdef HARAKA_S_PAD_EN
                    if (pad_pend_q) begin
                        fsm_d = StPad;
                    end
`endif
                end
            end
`ifdef HARAKA_S_PAD_EN
            StPad: begin
                state_d[RATE_BITS-1:0] = state_q[RATE_BITS-1:0] ^ PAD_BLOCK;
                pad_pend_d = 1'b0;
                start_d    = 1'b1;
                fsm_d      = StPermAbs;
            end
`endif
            StSqueeze: begin
                if (out_ready) begin
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        fsm_d    = StIdle;
                        state_d  = '0;
                        in_msg_d = 1'b0;
                        last_d   = 1'b0;
                    end else begin
                        fsm_d   = StPermSq;
                        start_d = 1'b1;
                    end
                end
            end
            StPermSq: begin
                if (perm_done) begin
                    state_d = perm_out;
                    fsm_d   = StSqueeze;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            cfg_q       <= 8'd1;
            remaining_q <= 8'd0;
            in_msg_q    <= 1'b0;
            last_q      <= 1'b0;
            start_q     <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            remaining_q <= remaining_d;
            in_msg_q    <= in_msg_d;
            last_q      <= last_d;
            start_q     <= start_d;
            init_q      <= 1'b1;
        end
    end

`ifdef HARAKA_S_PAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_pend_q <= 1'b0;
        end else begin
            pad_pend_q <= pad_pend_d;
        end
    end
`endif

    // init_q keeps in_ready low until the first clock edge after reset release.
    assign in_ready   = (fsm_q == StIdle) && init_q;
    assign perm_start = start_q;
    assign perm_in    = state_q;
    assign out_valid  = (fsm_q == StSqueeze);
    assign out_data   = state_q[RATE_BITS-1:0];
    assign busy       = (fsm_q != StIdle);

endmodule

// File: tb/tb_haraka_s_sponge.sv
// Scoreboard bench for haraka_s_sponge with a stub permutation and a byte-level sponge model.
// Expectations follow HARAKA_S_PAD_EN in the same way as the design.
module tb_haraka_s_sponge;

    localparam logic [255:0] PAD_BLK = {8'h80, 240'h0, 8'h1F};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   cfg_out_blocks = 8'd1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic         in_last = 1'b0;
    logic [5:0]   in_bytes = 6'd0;
    logic         perm_start;
    logic [511:0] perm_in;
    logic         perm_done;
    logic [511:0] perm_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    haraka_s_sponge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_out_blocks (cfg_out_blocks),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_bytes       (in_bytes),
        .perm_start     (perm_start),
        .perm_in        (perm_in),
        .perm_done      (perm_done),
        .perm_out       (perm_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [255:0] exp_q[$];
    logic [255:0] msg_q[$];
    logic [511:0] perm_log[$];
    int           perm_cnt = 0;
    int           hs_cnt = 0;
    logic [255:0] last_out = '0;

    bit           stub_en = 1'b1;
    int           stub_lat = 10;
    bit           perm_mode = 1'b0;
    int           stub_cnt = 0;
    logic [511:0] stub_in = '0;
    logic         stub_done = 1'b0;
    logic [511:0] stub_out = '0;
    logic         man_done = 1'b0;
    int           ready_mode = 0;

    assign perm_done = stub_done | man_done;
    assign perm_out  = stub_out;

    function automatic logic [511:0] perm_f(input bit mode, input logic [511:0] x);
        if (mode) return ~{x[510:0], x[511]} ^ {8{64'h0F1E2D3C4B5A6978}};
        return ~x;
    endfunction

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic report_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Stub round core: captures perm_in at perm_start, answers after stub_lat cycles.
    always @(negedge clk) begin
        stub_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                stub_done = 1'b1;
                stub_out  = perm_f(perm_mode, stub_in);
            end
        end
        if (perm_start) begin
            perm_cnt++;
            perm_log.push_back(perm_in);
            if (stub_en) begin
                stub_in  = perm_in;
                stub_cnt = stub_lat;
            end
        end
    end

    // Monitor: output scoreboard, stall stability, accept-to-start latency.
    bit           prev_acc = 1'b0;
    bit           prev_stall = 1'b0;
    logic [255:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_acc) check("start_after_accept", perm_start, 1);
            if (prev_stall && out_valid) check("stall_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_out = out_data;
                if (exp_q.size() == 0) report_fail("out_unexpected");
                else check("out_data", out_data, exp_q.pop_front());
            end
            prev_acc   = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_acc   = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // Consumer: 0 always ready, 1 random, 2 five stall cycles per block.
    int stall_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) begin
            out_ready = 1'b1;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 2) != 0);
        end else if (out_valid) begin
            if (stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            out_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    // Reference: byte-oriented pad10*1 sponge over the beats in msg_q.
    task automatic model(input logic [5:0] nb, input logic [7:0] cfg, output int nperm);
        byte unsigned bytes[$];
        logic [511:0] st;
        logic [255:0] blk;
        int n, nblk, cnt;
        st = '0;
        for (int b = 0; b < msg_q.size(); b++) begin
            n = 32;
`ifdef HARAKA_S_PAD_EN
            if (b == msg_q.size() - 1) n = (int'(nb) > 32) ? 32 : int'(nb);
`endif
            for (int k = 0; k < n; k++) bytes.push_back(msg_q[b][8*k +: 8]);
        end
`ifdef HARAKA_S_PAD_EN
        bytes.push_back(8'h1F);
        while (bytes.size() % 32 != 0) bytes.push_back(8'h00);
        bytes[bytes.size() - 1] = bytes[bytes.size() - 1] ^ 8'h80;
`endif
        nblk = bytes.size() / 32;
        for (int i = 0; i < nblk; i++) begin
            for (int k = 0; k < 32; k++) blk[8*k +: 8] = bytes[32*i + k];
            st[255:0] = st[255:0] ^ blk;
            st = perm_f(perm_mode, st);
        end
        cnt = (cfg == 8'd0) ? 1 : int'(cfg);
        for (int j = 0; j < cnt; j++) begin
            if (j > 0) st = perm_f(perm_mode, st);
            exp_q.push_back(st[255:0]);
        end
        nperm = nblk + cnt - 1;
    endtask

    task automatic send_beat(input logic [255:0] d, input bit last, input logic [5:0] nb);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 2000) begin
                report_fail("in_ready_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 5000);
        if (t >= 5000) begin
            report_fail("idle_timeout");
            exp_q.delete();
        end
    endtask

    task automatic do_msg(input logic [5:0] nb, input logic [7:0] cfg, input bit gaps);
        int nperm, base, g;
        bit last;
        model(nb, cfg, nperm);
        perm_log.delete();
        base = perm_cnt;
        cfg_out_blocks = cfg;
        for (int b = 0; b < msg_q.size(); b++) begin
            last = (b == msg_q.size() - 1);
            send_beat(msg_q[b], last, last ? nb : 6'($urandom_range(0, 63)));
            if (gaps) begin
                cfg_out_blocks = 8'($urandom);
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();
        check("perm_count", perm_cnt - base, nperm);
        @(posedge clk);
        #1;
    endtask

    logic [255:0] beat;
    int           hs_base;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_perm_start", perm_start, 0);
        check("rst_perm_in", perm_in, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Empty message, all-ones data
        msg_q.delete();
        msg_q.push_back({256{1'b1}});
        do_msg(6'd0, 8'd1, 1'b0);
`ifdef HARAKA_S_PAD_EN
        check("empty_perm_in", perm_log[0][255:0], PAD_BLK);
        check("empty_out", last_out, {8'h7F, {30{8'hFF}}, 8'hE0});
`else
        check("empty_perm_in", perm_log[0][255:0], {256{1'b1}});
        check("empty_out", last_out, 256'h0);
`endif

        // Full 32-byte last beat
        beat = rand256();
        msg_q.delete();
        msg_q.push_back(beat);
        do_msg(6'd32, 8'd1, 1'b0);
`ifdef HARAKA_S_PAD_EN
        check("full_beat_perms", perm_log.size(), 2);
        if (perm_log.size() > 1) check("pad_block_perm_in", perm_log[1][255:0], ~beat ^ PAD_BLK);
`else
        check("full_beat_perms", perm_log.size(), 1);
`endif

`ifdef HARAKA_S_PAD_EN
        // 31 bytes: both pad bytes collide on byte 31
        msg_q.delete();
        msg_q.push_back({32{8'hAA}});
        do_msg(6'd31, 8'd1, 1'b0);
        check("bytes31_perm_in", perm_log[0][255:0], {8'h9F, {31{8'hAA}}});
`else
        // Caller pre-pads: in_bytes has no effect
        beat = rand256();
        msg_q.delete();
        msg_q.push_back(beat);
        do_msg(6'd5, 8'd1, 1'b0);
        check("raw_perm_in", perm_log[0][255:0], beat);
        check("raw_perm_count", perm_log.size(), 1);
`endif

        // Three output blocks with back-pressure
        ready_mode = 2;
        hs_base = hs_cnt;
        msg_q.delete();
        msg_q.push_back(rand256());
        do_msg(6'd10, 8'd3, 1'b0);
        check("stall_handshakes", hs_cnt - hs_base, 3);
        ready_mode = 0;

        // Reset while waiting on a permutation
        stub_en = 1'b0;
        cfg_out_blocks = 8'd1;
        send_beat(rand256(), 1'b1, 6'd4);
        repeat (2) @(posedge clk);
        #1;
        check("perm_abs_busy", busy, 1);
        check("perm_abs_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_perm_in", perm_in, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_in_ready", in_ready, 1);
            check("post_rst_perm_start", perm_start, 0);
        end
        stub_en = 1'b1;
        @(posedge clk);
        #1;

        // Randomized messages
        perm_mode  = 1'b1;
        ready_mode = 1;
        for (int m = 0; m < 25; m++) begin
            int nbeats;
            nbeats = $urandom_range(1, 4);
            msg_q.delete();
            for (int b = 0; b < nbeats; b++) msg_q.push_back(rand256());
            stub_lat = $urandom_range(1, 6);
            do_msg(6'($urandom_range(0, 40)), 8'($urandom_range(0, 4)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/haraka_s_sponge.md
# haraka_s_sponge

Sponge-mode front end for the Haraka-S hash. It accepts message beats on a valid/ready stream, applies the padding rule and XORs each beat into the 256-bit rate of a 512-bit state. It issues each permutation call to the round core through a start/done handshake, then streams squeezed output blocks on a second valid/ready stream. It is the initiator of the permutation interface; the round core is the responder.

## Interface
- RATE_BITS, 256, rate portion of state (state bits [255:0])
- STATE_BITS, 512, full sponge state width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_out_blocks  in  8  number of 256-bit output blocks; sampled on first accepted beat; 0 treated as 1
- in_valid  in  1  message beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  256  message bytes, byte k = bits [8k+7:8k]
- in_last  in  1  final beat of message
- in_bytes  in  6  valid bytes in last beat, 0..32; 33..63 saturate to 32; ignored when in_last=0
- perm_start  out  1  one-cycle pulse requesting one permutation
- perm_in  out  512  state to permute; stable from perm_start until perm_done
- perm_done  in  1  one-cycle pulse, perm_out valid
- perm_out  in  512  permuted state
- out_valid  out  1  output block valid
- out_ready  in  1  consumer accepts block
- out_data  out  256  squeezed block = state[255:0]
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PERM_ABS, PAD, SQUEEZE, PERM_SQ.
- IDLE: state=0, in_ready=1. On in_valid&&in_ready: state[255:0] ^= beat' (beat' = masked/padded beat when in_last, raw beat otherwise); latch cfg_out_blocks on first beat of message; -> PERM_ABS.
- Non-last beats absorbed raw, all 32 bytes.
- Padding on last beat: bytes >= in_bytes zeroed; byte[in_bytes] ^= 0x1F; byte[31] ^= 0x80 (in_bytes=31 -> byte31 ^= 0x9F). If in_bytes=32, beat absorbed raw and a pad-only block (byte0=0x1F, byte31=0x80) follows via PAD.
- PERM_ABS: wait perm_done; state <= perm_out. Then: more beats -> IDLE-equivalent accept (in_ready=1, message continues, cfg not re-sampled); pad pending -> PAD; last absorbed -> SQUEEZE with remaining = latched count.
- PAD: state[255:0] ^= pad block, -> PERM_ABS (no input consumed).
- SQUEEZE: out_valid=1, out_data=state[255:0]. On handshake remaining--; remaining hits 0 -> IDLE and state cleared; else -> PERM_SQ.
- PERM_SQ: wait perm_done, state <= perm_out, -> SQUEEZE.
- perm_done outside PERM_ABS/PERM_SQ ignored.
- Absorb/squeeze counter 8 bits; no wrap possible since count <= 255.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release; perm_start=0, perm_in=0, out_valid=0, out_data=0, busy=0.
- Beat accepted cycle N -> perm_start high cycle N+1 exactly one cycle.
- Permutation latency arbitrary (>=1 cycle); perm_done cycle M -> out_valid or in_ready high cycle M+1.
- PAD costs one cycle between perm_done and next perm_start.
- out_valid held, out_data stable while out_ready=0.
- in_ready=0 in PERM_ABS, PAD, SQUEEZE, PERM_SQ.
- Reset mid-operation: immediate return to IDLE, state zeroed, any in-flight perm_done after release ignored.

## Configuration
- HARAKA_S_PAD_EN defined: padding as above, in_bytes honoured, PAD state present.
- Undefined: in_bytes ignored, every beat absorbed raw (caller pre-pads), no PAD state; in_last only ends absorption.

## Structure
- Shared package haraka_s_pkg: state enum, RATE_BITS/STATE_BITS, PAD_FIRST=8'h1F, PAD_LAST=8'h80, pad-block constant.
- Sub-module haraka_s_pad: combinational mask+pad of last beat from in_data/in_bytes, plus pad_pending flag.

## Test plan
- Stub permutation perm_out=~perm_in, latency 10; empty message (in_last=1, in_bytes=0, in_data all 1s), cfg_out_blocks=1 -> one perm_start; out_data byte0=0xE0, byte31=0x7F, other bytes 0xFF.
- Single last beat in_bytes=32 -> exactly two perm_start pulses, second perm_in[255:0] = ~beat ^ pad block.
- in_bytes=31 data 0xAA -> first perm_in byte31=0x9F, bytes0..30=0xAA.
- cfg_out_blocks=3, out_ready low 5 cycles per block -> 3 handshakes, out_data stable while stalled, total perm_start = 1+2.
- rst_n low while in PERM_ABS, perm_done pulsed 2 cycles after release -> state stays IDLE, out_valid=0, in_ready=1.
- Macro undefined, in_bytes=5 last beat -> perm_in[255:0] equals raw in_data, one perm_start.
